// File: rtl/reg_and_tree_pkg.sv
// Shared constants for the reg_and_tree reduction pipeline: legal parameter
// limits, op encoding, counter width and tree-shape helper functions.
package reg_and_tree_pkg;

    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 32;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_OR  = 1'b1;

    localparam int CNT_W = 16;

    // Number of pairwise levels needed to reduce n channels to one.
    function automatic int tree_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int i = 0; i < 5; i++) begin
            if (c > 1) begin
                c = (c + 1) / 2;
                l++;
            end
        end
        return l;
    endfunction

    // Channels remaining after the given number of pairwise levels.
    function automatic int chan_after(input int n, input int levels);
        int c;
        c = n;
        for (int i = 0; i < 5; i++) begin
            if (i < levels) c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_and_tree_stage.sv
// One pipeline register holding valid, op and data; loads only when the
// pipeline advances, otherwise holds its contents.
module reg_and_tree_stage
    import reg_and_tree_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_vld,
    input  logic         i_op,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic         o_op,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic         r_op;
    logic [W-1:0] r_data;

    // Stall-controlled capture of the whole beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_op   <= OP_AND;
            r_data <= '0;
        end else if (i_en) begin
            r_vld  <= i_vld;
            r_op   <= i_op;
            r_data <= i_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_op   = r_op;
    assign o_data = r_data;

endmodule

// File: rtl/reg_and_tree.sv
// Pipelined AND/OR reduction of NUM_IN channels of WIDTH bits.
// A capture stage is followed by STAGES reduction stages; the pairwise tree
// levels are split evenly across the reduction stages. A single stall signal
// (result present but not taken) freezes every stage.
// Optional feature: define REG_AND_TREE_PARITY_EN to add out_parity, the even
// parity of out_data registered alongside it.
module reg_and_tree
    import reg_and_tree_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_op,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        out_count
`ifdef REG_AND_TREE_PARITY_EN
    ,
    output logic                    out_parity
`endif
);

    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("reg_and_tree: NUM_IN out of range");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("reg_and_tree: WIDTH out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("reg_and_tree: STAGES out of range");
    end

    localparam int LEVELS = tree_levels(NUM_IN);

    logic [STAGES:0]         w_vld;
    logic [STAGES:0]         w_op;
    logic [NUM_IN*WIDTH-1:0] w_cap_data;
    logic                    w_stall;
    logic                    w_adv;
    logic [CNT_W-1:0]        r_count;
    logic                    w_unused_last_op;

    assign w_stall  = w_vld[STAGES] && !out_ready;
    assign w_adv    = !w_stall;
    assign in_ready = w_adv;

    // The last stage op has no consumer downstream.
    assign w_unused_last_op = w_op[STAGES];

    reg_and_tree_stage #(.W(NUM_IN*WIDTH)) u_cap (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_adv),
        .i_vld  (in_valid),
        .i_op   (in_op),
        .i_data (in_data),
        .o_vld  (w_vld[0]),
        .o_op   (w_op[0]),
        .o_data (w_cap_data)
    );

    for (genvar s = 1; s <= STAGES; s++) begin : g_red
        localparam int LO = ((s - 1) * LEVELS) / STAGES;
        localparam int HI = (s * LEVELS) / STAGES;
        localparam int NI = chan_after(NUM_IN, LO);
        localparam int NO = chan_after(NUM_IN, HI);

        logic [NI*WIDTH-1:0] w_in;
        logic [NO*WIDTH-1:0] w_red;
        logic [NO*WIDTH-1:0] w_q;

        if (s == 1) begin : g_first
            assign w_in = w_cap_data;
        end else begin : g_next
            assign w_in = g_red[s-1].w_q;
        end

        // Apply this stage's share of tree levels; pairs combine into the
        // low slots in place, an odd leftover moves down unchanged.
        always_comb begin
            logic [WIDTH-1:0] v [NI];
            int n;
            for (int j = 0; j < NI; j++) v[j] = w_in[j*WIDTH +: WIDTH];
            n = NI;
            for (int l = LO; l < HI; l++) begin
                for (int j = 0; j < NI / 2; j++) begin
                    if (2 * j + 1 < n) begin
                        v[j] = (w_op[s-1] == OP_OR) ? (v[2*j] | v[2*j+1])
                                                    : (v[2*j] & v[2*j+1]);
                    end
                end
                if (n % 2 == 1) v[n/2] = v[n-1];
                n = (n + 1) / 2;
            end
            w_red = '0;
            for (int j = 0; j < NO; j++) w_red[j*WIDTH +: WIDTH] = v[j];
        end

        reg_and_tree_stage #(.W(NO*WIDTH)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_vld  (w_vld[s-1]),
            .i_op   (w_op[s-1]),
            .i_data (w_red),
            .o_vld  (w_vld[s]),
            .o_op   (w_op[s]),
            .o_data (w_q)
        );
    end

    assign out_data  = g_red[STAGES].w_q;
    assign out_valid = w_vld[STAGES];

    // Delivered-result counter, wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_vld[STAGES] && out_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign out_count = r_count;

`ifdef REG_AND_TREE_PARITY_EN
    logic r_parity;

    // Parity tracks the last stage data register edge for edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_adv) begin
            r_parity <= ^g_red[STAGES].w_red;
        end
    end

    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_reg_and_tree.sv
// Directed bench for reg_and_tree: a default instance (3 x 1 bit, 2 stages)
// and a 4 x 8 bit instance for the OR/AND word cases.
module tb_reg_and_tree;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Default instance signals
    logic [2:0]  a_in_data = '0;
    logic        a_in_op = 1'b0;
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [0:0]  a_out_data;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [15:0] a_out_count;

    // 4 x 8 instance signals
    logic [31:0] b_in_data = '0;
    logic        b_in_op = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_count;

`ifdef REG_AND_TREE_PARITY_EN
    logic a_out_parity;
    logic b_out_parity;
`endif

    reg_and_tree u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_op     (a_in_op),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_count (a_out_count)
`ifdef REG_AND_TREE_PARITY_EN
        ,
        .out_parity(a_out_parity)
`endif
    );

    reg_and_tree #(.NUM_IN(4), .WIDTH(8), .STAGES(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_op     (b_in_op),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_count (b_out_count)
`ifdef REG_AND_TREE_PARITY_EN
        ,
        .out_parity(b_out_parity)
`endif
    );

    typedef struct {
        logic [2:0] d;
        logic       op;
        logic       exp;
    } vec_a_t;

    typedef struct {
        logic [31:0] d;
        logic        op;
        logic [7:0]  exp;
    } vec_b_t;

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] a_exp_cnt = '0;
    logic [15:0] b_exp_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One isolated beat on instance A: checks latency, data and count.
    task automatic beat_a(input logic [2:0] d, input logic op, input logic exp_d, input string nm);
        int lat;
        @(posedge clk); #1;
        a_in_data  = d;
        a_in_op    = op;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 3);
        chk({nm, " data"}, a_out_data, exp_d);
        @(posedge clk); #1;
        a_exp_cnt = a_exp_cnt + 16'd1;
        chk({nm, " count"}, a_out_count, a_exp_cnt);
    endtask

    // One isolated beat on instance B.
    task automatic beat_b(input logic [31:0] d, input logic op, input logic [7:0] exp_d, input string nm);
        int lat;
        @(posedge clk); #1;
        b_in_data  = d;
        b_in_op    = op;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 3);
        chk({nm, " data"}, b_out_data, exp_d);
`ifdef REG_AND_TREE_PARITY_EN
        chk({nm, " parity"}, b_out_parity, ^exp_d);
`endif
        @(posedge clk); #1;
        b_exp_cnt = b_exp_cnt + 16'd1;
        chk({nm, " count"}, b_out_count, b_exp_cnt);
    endtask

    vec_a_t va[9];
    vec_b_t vb[8];
    vec_a_t bp[6];

    initial begin
        int sent;
        int got;
        int low;
        int wait_cyc;
        int ghost;
        logic stall;

        va[0] = '{3'b111, 1'b0, 1'b1};
        va[1] = '{3'b101, 1'b0, 1'b0};
        va[2] = '{3'b011, 1'b0, 1'b0};
        va[3] = '{3'b110, 1'b0, 1'b0};
        va[4] = '{3'b000, 1'b1, 1'b0};
        va[5] = '{3'b001, 1'b1, 1'b1};
        va[6] = '{3'b100, 1'b1, 1'b1};
        va[7] = '{3'b010, 1'b1, 1'b1};
        va[8] = '{3'b111, 1'b1, 1'b1};

        vb[0] = '{32'h8004_0201, 1'b1, 8'h87};
        vb[1] = '{32'h8004_0201, 1'b0, 8'h00};
        vb[2] = '{32'hFFFF_FFFF, 1'b0, 8'hFF};
        vb[3] = '{32'hFF3F_FF0F, 1'b0, 8'h0F};
        vb[4] = '{32'h0000_0000, 1'b1, 8'h00};
        vb[5] = '{32'h1000_0000, 1'b1, 8'h10};
        vb[6] = '{32'h0F0F_0F0F, 1'b0, 8'h0F};
        vb[7] = '{32'h0000_0040, 1'b1, 8'h40};

        bp[0] = '{3'b111, 1'b0, 1'b1};
        bp[1] = '{3'b101, 1'b1, 1'b1};
        bp[2] = '{3'b000, 1'b1, 1'b0};
        bp[3] = '{3'b110, 1'b0, 1'b0};
        bp[4] = '{3'b111, 1'b1, 1'b1};
        bp[5] = '{3'b010, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", a_out_valid, 0);
        chk("reset out_count", a_out_count, 0);
        chk("reset in_ready", a_in_ready, 1);
        chk("reset out_data", a_out_data, 0);
        chk("reset b out_data", b_out_data, 0);
        rst_n = 1'b1;

        // Table-driven single beats
        for (int i = 0; i < 9; i++) beat_a(va[i].d, va[i].op, va[i].exp, $sformatf("A vec%0d", i));
        for (int i = 0; i < 8; i++) beat_b(vb[i].d, vb[i].op, vb[i].exp, $sformatf("B vec%0d", i));

        // Back-pressure: 6 beats, out_ready low for cycles 4..7
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a_exp_cnt = '0;
        sent = 0;
        got = 0;
        low = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(posedge clk); #1;
            a_out_ready = !(c >= 4 && c < 8);
            a_in_valid  = (sent < 6);
            if (sent < 6) begin
                a_in_data = bp[sent].d;
                a_in_op   = bp[sent].op;
            end
            @(negedge clk);
            stall = a_out_valid && !a_out_ready;
            chk("bp in_ready", a_in_ready, !stall);
            if (!a_in_ready) low++;
            if (a_in_valid && a_in_ready) sent++;
            if (a_out_valid && a_out_ready) begin
                if (got < 6) chk($sformatf("bp result%0d", got), a_out_data, bp[got].exp);
                else chk("bp extra result", got, 5);
                got++;
            end
        end
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("bp beats sent", sent, 6);
        chk("bp results", got, 6);
        chk("bp ready-low cycles", low, 4);
        chk("bp out_count", a_out_count, 6);

        // Reset mid-flight: two beats held in the stalled pipeline
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 3'b111;
        a_in_op     = 1'b0;
        @(posedge clk); #1;
        a_in_data   = 3'b010;
        a_in_op     = 1'b1;
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        wait_cyc = 0;
        while (!a_out_valid && wait_cyc < 10) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("mid out_valid before reset", a_out_valid, 1);
        chk("mid in_ready stalled", a_in_ready, 0);
        rst_n      = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 3'b111;
        a_in_op    = 1'b1;
        #1;
        chk("mid out_valid in reset", a_out_valid, 0);
        chk("mid out_count in reset", a_out_count, 0);
        chk("mid in_ready in reset", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        ghost = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_out_valid) ghost++;
        end
        chk("mid no ghost result", ghost, 0);
        a_exp_cnt = '0;
        beat_a(3'b011, 1'b1, 1'b1, "post-reset beat");

        // Counter wrap: 65536 deliveries from reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a_in_data  = 3'b111;
        a_in_op    = 1'b0;
        a_in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("wrap count at 0xFFFF", a_out_count, 16'hFFFF);
        a_exp_cnt = 16'hFFFF;
        beat_a(3'b111, 1'b0, 1'b1, "wrap beat");
        chk("wrap count at 0x0000", a_out_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
